adc_avg_monitor: RTL and testbench

ADC_AVG_MONITOR -- requirements
Module: adc_avg_monitor

---
 rtl/adc_avg_monitor.sv | 137 +++++++++++++
 tb/tb_adc_avg_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_monitor.sv
// Moving-average filter over the last 2**AVG_LOG2 ADC samples, with a
// sticky over-limit fault raised after OC_COUNT consecutive high codes.
module adc_avg_monitor #(
   parameter int              BITS      = 12,
   parameter int              AVG_LOG2  = 3,
   parameter logic [BITS-1:0] OC_THRESH = BITS'(3500),
   parameter int              OC_COUNT  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] sample_in,
   input  logic            sample_valid,
   input  logic            clear_fault,
   output logic [BITS-1:0] avg_out,
   output logic            avg_valid,
   output logic            over_limit,
   output logic            filled
);

   localparam int N     = 32'd1 << AVG_LOG2;
   localparam int SUM_W = BITS + AVG_LOG2;
   localparam int CNT_W = $clog2(OC_COUNT + 1);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic [BITS-1:0]     sample_buf_r [N];
   logic [SUM_W-1:0]    sum_r;
   logic [SUM_W-1:0]    sum_next_s;
   logic [AVG_LOG2-1:0] wr_ptr_r;
   logic [AVG_LOG2-1:0] fill_cnt_r;
   logic [CNT_W-1:0]    oc_cnt_r;
   logic [CNT_W-1:0]    oc_cnt_next_s;
   logic                over_limit_next_s;
   logic                fill_done_s;
   logic                emit_s;
   logic                over_s;
   logic                reach_s;
   logic [BITS-1:0]     avg_out_r;
   logic                avg_valid_r;
   logic                over_limit_r;
   logic                filled_r;

   // Sum always equals the buffer contents, so subtracting the oldest entry cannot underflow.
   assign sum_next_s = sum_r + SUM_W'(sample_in) - SUM_W'(sample_buf_r[wr_ptr_r]);
   assign over_s     = (sample_in >= OC_THRESH);
   assign reach_s    = sample_valid && over_s && (oc_cnt_r == CNT_W'(OC_COUNT - 1));
   assign emit_s     = sample_valid && ((state_r == ST_RUN) || fill_done_s);

   // Fill/run sequencing: the Nth accepted sample completes the window.
   always_comb begin
      state_next_s = state_r;
      fill_done_s  = 1'b0;
      case (state_r)
         ST_FILL: begin
            if (sample_valid && (fill_cnt_r == AVG_LOG2'(N - 1))) begin
               state_next_s = ST_RUN;
               fill_done_s  = 1'b1;
            end else begin
               state_next_s = ST_FILL;
            end
         end
         ST_RUN:  state_next_s = ST_RUN;
         default: state_next_s = ST_FILL;
      endcase
   end

   // Consecutive over-threshold counter and fault flag; a completing sample beats clear_fault.
   always_comb begin
      oc_cnt_next_s     = oc_cnt_r;
      over_limit_next_s = over_limit_r;
      if (reach_s) begin
         oc_cnt_next_s     = CNT_W'(OC_COUNT);
         over_limit_next_s = 1'b1;
      end else if (clear_fault) begin
         oc_cnt_next_s     = (sample_valid && over_s) ? CNT_W'(1) : {CNT_W{1'b0}};
         over_limit_next_s = 1'b0;
      end else if (sample_valid) begin
         if (!over_s) begin
            oc_cnt_next_s = {CNT_W{1'b0}};
         end else if (oc_cnt_r == CNT_W'(OC_COUNT)) begin
            oc_cnt_next_s = oc_cnt_r;
         end else begin
            oc_cnt_next_s = oc_cnt_r + CNT_W'(1);
         end
      end else begin
         oc_cnt_next_s = oc_cnt_r;
      end
   end

   // State, sample window and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            sample_buf_r[i] <= {BITS{1'b0}};
         end
         sum_r        <= {SUM_W{1'b0}};
         wr_ptr_r     <= {AVG_LOG2{1'b0}};
         fill_cnt_r   <= {AVG_LOG2{1'b0}};
         oc_cnt_r     <= {CNT_W{1'b0}};
         state_r      <= ST_FILL;
         avg_out_r    <= {BITS{1'b0}};
         avg_valid_r  <= 1'b0;
         over_limit_r <= 1'b0;
         filled_r     <= 1'b0;
      end else begin
         if (sample_valid) begin
            sum_r                  <= sum_next_s;
            sample_buf_r[wr_ptr_r] <= sample_in;
            wr_ptr_r               <= wr_ptr_r + AVG_LOG2'(1);
         end
         if (sample_valid && (state_r == ST_FILL)) begin
            fill_cnt_r <= fill_cnt_r + AVG_LOG2'(1);
         end
         if (emit_s) begin
            avg_out_r <= BITS'(sum_next_s >> AVG_LOG2);
         end
         if (fill_done_s) begin
            filled_r <= 1'b1;
         end
         state_r      <= state_next_s;
         avg_valid_r  <= emit_s;
         oc_cnt_r     <= oc_cnt_next_s;
         over_limit_r <= over_limit_next_s;
      end
   end

   assign avg_out    = avg_out_r;
   assign avg_valid  = avg_valid_r;
   assign over_limit = over_limit_r;
   assign filled     = filled_r;

endmodule

// File: tb/tb_adc_avg_monitor.sv
// Scoreboard bench for adc_avg_monitor: stimulus pushes hand-computed averages,
// a negedge monitor pops and compares them whenever avg_valid is expected or seen.
module tb_adc_avg_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] sample_in;
   logic        sample_valid;
   logic        clear_fault;
   logic [11:0] avg_out;
   logic        avg_valid;
   logic        over_limit;
   logic        filled;

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [11:0] exp_q [$];
   logic [11:0] mon_exp;

   adc_avg_monitor dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .clear_fault  (clear_fault),
      .avg_out      (avg_out),
      .avg_valid    (avg_valid),
      .over_limit   (over_limit),
      .filled       (filled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: every expected average must appear at the negedge right after its sample edge.
   always @(negedge clk) begin
      if (avg_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected avg_valid", 1, 0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("avg_out", int'(avg_out), int'(mon_exp));
         end
      end else if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         chk("missing avg_valid", 0, 1);
      end
   end

   task automatic send(input logic [11:0] s, input bit exp_v, input logic [11:0] exp_avg,
                       input bit clr);
      sample_in    = s;
      sample_valid = 1'b1;
      clear_fault  = clr;
      @(posedge clk);
      if (exp_v) exp_q.push_back(exp_avg);
      #1;
      sample_valid = 1'b0;
      clear_fault  = 1'b0;
   endtask

   task automatic idle(input int n, input bit clr);
      clear_fault = clr;
      repeat (n) @(posedge clk);
      #1;
      clear_fault = 1'b0;
   endtask

   int slide_exp   [8] = '{1125, 1250, 1375, 1500, 1625, 1750, 1875, 2000};
   int extreme_exp [8] = '{2261, 2523, 2785, 3047, 3309, 3571, 3833, 4095};
   int oc_vals     [7] = '{3500, 3600, 3499, 3500, 3500, 3500, 3500};

   initial begin
      // Reset with a sample pending: it must be discarded.
      rst          = 1'b1;
      sample_valid = 1'b1;
      sample_in    = 12'd1234;
      clear_fault  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst          = 1'b0;
      sample_valid = 1'b0;
      @(negedge clk);
      chk("reset avg_out", int'(avg_out), 0);
      chk("reset avg_valid", int'(avg_valid), 0);
      chk("reset over_limit", int'(over_limit), 0);
      chk("reset filled", int'(filled), 0);

      // Fill with 1000
      for (int i = 0; i < 7; i++) send(12'd1000, 1'b0, 12'd0, 1'b0);
      @(negedge clk);
      chk("filled before 8th", int'(filled), 0);
      send(12'd1000, 1'b1, 12'd1000, 1'b0);
      @(negedge clk);
      chk("filled after 8th", int'(filled), 1);

      // Slide to 2000 across the pointer wrap, then hold during idle cycles
      for (int i = 0; i < 8; i++) send(12'd2000, 1'b1, 12'(slide_exp[i]), 1'b0);
      send(12'd2000, 1'b1, 12'd2000, 1'b0);
      idle(3, 1'b0);
      @(negedge clk);
      chk("avg hold idle", int'(avg_out), 2000);

      // Extremes; the 4095 run also trips the fault on its 4th sample
      for (int i = 0; i < 8; i++) begin
         send(12'd4095, 1'b1, 12'(extreme_exp[i]), 1'b0);
         if (i == 2) begin
            @(negedge clk);
            chk("ol after 3 x 4095", int'(over_limit), 0);
         end else if (i == 3) begin
            @(negedge clk);
            chk("ol after 4 x 4095", int'(over_limit), 1);
         end
      end
      send(12'd0, 1'b1, 12'd3583, 1'b0);

      // Reset mid-run with sample and clear_fault asserted
      sample_in    = 12'd4000;
      sample_valid = 1'b1;
      clear_fault  = 1'b1;
      rst          = 1'b1;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      sample_valid = 1'b0;
      clear_fault  = 1'b0;
      @(negedge clk);
      chk("midrun rst avg_out", int'(avg_out), 0);
      chk("midrun rst avg_valid", int'(avg_valid), 0);
      chk("midrun rst over_limit", int'(over_limit), 0);
      chk("midrun rst filled", int'(filled), 0);

      // Over-limit sequence while still filling
      for (int i = 0; i < 7; i++) begin
         send(12'(oc_vals[i]), 1'b0, 12'd0, 1'b0);
         @(negedge clk);
         chk($sformatf("ol seq %0d", i), int'(over_limit), (i == 6) ? 1 : 0);
      end
      chk("filled after 7 post-rst", int'(filled), 0);
      send(12'd0, 1'b1, 12'd3074, 1'b0);
      @(negedge clk);
      chk("filled after 8 post-rst", int'(filled), 1);
      send(12'd0, 1'b1, 12'd2637, 1'b0);
      @(negedge clk);
      chk("ol sticky", int'(over_limit), 1);
      idle(1, 1'b1);
      @(negedge clk);
      chk("ol cleared", int'(over_limit), 0);

      // Clear coinciding with a completing sample: set wins
      send(12'd4000, 1'b1, 12'd2687, 1'b0);
      send(12'd4000, 1'b1, 12'd2750, 1'b0);
      send(12'd4000, 1'b1, 12'd2812, 1'b0);
      @(negedge clk);
      chk("ol cnt 3", int'(over_limit), 0);
      send(12'd4000, 1'b1, 12'd2875, 1'b1);
      @(negedge clk);
      chk("ol set beats clear", int'(over_limit), 1);
      idle(1, 1'b1);
      @(negedge clk);
      chk("ol cleared again", int'(over_limit), 0);

      // Clear coinciding with a low sample: counter must end at 0
      send(12'd4000, 1'b1, 12'd2937, 1'b0);
      send(12'd100, 1'b1, 12'd2512, 1'b1);
      @(negedge clk);
      chk("ol clear with low", int'(over_limit), 0);
      send(12'd4000, 1'b1, 12'd3012, 1'b0);
      send(12'd4000, 1'b1, 12'd3512, 1'b0);
      send(12'd4000, 1'b1, 12'd3512, 1'b0);
      @(negedge clk);
      chk("ol cnt restarted", int'(over_limit), 0);
      send(12'd4000, 1'b1, 12'd3512, 1'b0);
      @(negedge clk);
      chk("ol after 4 fresh", int'(over_limit), 1);

      idle(2, 1'b0);
      @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
